// File: rtl/sd_rx_pack_fifo_pkg.sv
// Shared encodings and helpers for the SD/MMC receive packer FIFO.
// The build macro SD_RX_BYTE_SWAP_EN (used by the packer) selects big-endian byte lanes.
package sd_rx_pkg;

  localparam int SD_RX_WORD_W = 32;

  typedef enum logic [1:0] {
    SD_BW_1   = 2'd0,
    SD_BW_4   = 2'd1,
    SD_BW_8   = 2'd2,
    SD_BW_RSV = 2'd3
  } sd_bw_e;

  // Bits per card-line sample; the reserved encoding behaves as 4-bit.
  function automatic logic [3:0] sd_unit_w(input logic [1:0] bw);
    case (bw)
      SD_BW_1: return 4'd1;
      SD_BW_8: return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [SD_RX_WORD_W-1:0] sd_byte_swap(input logic [SD_RX_WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sd_rx_pack_fifo_if.sv
// Card-line sample input and host-side read port of the receive packer FIFO.
interface sd_rx_pack_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]  bus_w;
  logic [7:0]  d;
  logic        wr;
  logic        flush;
  logic        rd;
  logic        clr_ovf;
  logic [31:0] q;
  logic        empty;
  logic        full;
  logic        afull;
  logic [AW:0] level;
  logic        ovf;

  modport master (
    output bus_w, d, wr, flush, rd, clr_ovf,
    input  q, empty, full, afull, level, ovf
  );

  modport slave (
    input  bus_w, d, wr, flush, rd, clr_ovf,
    output q, empty, full, afull, level, ovf
  );

endinterface

// File: rtl/sd_rx_pack_fifo_packer.sv
// Packs 1/4/8-bit card-line samples into 32-bit words; flush pushes a zero-padded partial word.
// Build macro SD_RX_BYTE_SWAP_EN reverses byte lanes of the pushed word.
module sd_rx_packer
  import sd_rx_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              bus_w,
  input  logic [7:0]              d,
  input  logic                    wr,
  input  logic                    flush,
  output logic                    push,
  output logic [SD_RX_WORD_W-1:0] word
);

  logic [5:0]              fill;
  logic [5:0]              fill_nxt;
  logic [SD_RX_WORD_W-1:0] sr;
  logic [SD_RX_WORD_W-1:0] sr_nxt;
  logic [1:0]              bw_lat;
  logic [1:0]              bw_eff;
  logic [3:0]              unit;
  logic [4:0]              pos;
  logic [7:0]              smask;
  logic [SD_RX_WORD_W-1:0] sample;

  always_comb begin
    bw_eff   = (fill == 6'd0) ? bus_w : bw_lat;
    unit     = sd_unit_w(bw_eff);
    smask    = 8'hFF >> (4'd8 - unit);
    // Earliest bits sit at the top of each byte; bytes fill upward from lane 0.
    pos      = {fill[4:3], 3'b000} + 5'd8 - {2'b00, fill[2:0]} - {1'b0, unit};
    sample   = {24'h0, d & smask} << pos;
    fill_nxt = fill;
    sr_nxt   = sr;
    if (wr) begin
      fill_nxt = fill + {2'b00, unit};
      sr_nxt   = sr | sample;
    end
    push = (fill_nxt == 6'd32) || (flush && (fill_nxt != 6'd0));
`ifdef SD_RX_BYTE_SWAP_EN
    word = sd_byte_swap(sr_nxt);
`else
    word = sr_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill   <= 6'd0;
      sr     <= '0;
      bw_lat <= SD_BW_1;
    end else begin
      if (wr && (fill == 6'd0)) bw_lat <= bus_w;
      if (push) begin
        fill <= 6'd0;
        sr   <= '0;
      end else begin
        fill <= fill_nxt;
        sr   <= sr_nxt;
      end
    end
  end

endmodule

// File: rtl/sd_rx_pack_fifo.sv
// Single-clock SD/MMC receive FIFO: sample packer feeding a first-word-fall-through word store.
// Build macro SD_RX_BYTE_SWAP_EN (see packer) selects big-endian byte lanes on q.
module sd_rx_pack_fifo
  import sd_rx_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sd_rx_pack_fifo_if.slave bus
);

  localparam logic [AW:0] AF_LVL  = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic                    push;
  logic [SD_RX_WORD_W-1:0] word;
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic [AW:0]             lvl;
  logic                    empty_i;
  logic                    full_i;
  logic                    push_ok;
  logic                    pop;
  logic                    ovf_r;
  logic [SD_RX_WORD_W-1:0] mem [DEPTH];

  sd_rx_packer u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_w (bus.bus_w),
    .d     (bus.d),
    .wr    (bus.wr),
    .flush (bus.flush),
    .push  (push),
    .word  (word)
  );

  assign empty_i = (wr_ptr == rd_ptr);
  assign full_i  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign lvl     = wr_ptr - rd_ptr;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok = push && (!full_i || bus.rd);
  assign pop     = bus.rd && !empty_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !push_ok) ovf_r <= 1'b1;
      else if (bus.clr_ovf) ovf_r <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= word;
  end

  assign bus.q     = mem[rd_ptr[AW-1:0]];
  assign bus.empty = empty_i;
  assign bus.full  = full_i;
  assign bus.afull = (lvl >= AF_LVL);
  assign bus.level = lvl;
  assign bus.ovf   = ovf_r;

endmodule

// File: doc/sd_rx_pack_fifo.md
Name: sd_rx_pack_fifo

Overview:
Single-clock receive FIFO for the SD/MMC master data path. It packs 1-, 4- or 8-bit card-line samples into 32-bit words, with bus width selectable at run time. Words are stored in a parametrised-depth FIFO read by the host/DMA side. Compared with the fixed 4-bit dual-clock RX FIFO, it adds:
- run-time bus width
- end-of-block flush with zero padding
- fill level and almost-full outputs
- sticky overflow flag

Parameters:
DEPTH, 8, FIFO depth in 32-bit words; power of 2, minimum 2
AW, $clog2(DEPTH), pointer index width (derived; do not override)
AF_LEVEL, DEPTH-2, level at or above which afull asserts

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
bus_w  in  2  line width: 0=1-bit, 1=4-bit, 2=8-bit, 3=reserved (treated as 4-bit)
d  in  8  line sample; 1-bit mode uses d[0], 4-bit uses d[3:0]
wr  in  1  d valid this cycle
flush  in  1  end of block: push partial word zero-padded
rd  in  1  pop head word (ignored when empty)
q  out  32  head word, first-word-fall-through
empty  out  1  no words stored
full  out  1  DEPTH words stored
afull  out  1  level >= AF_LEVEL
level  out  AW+1  words stored, 0..DEPTH
ovf  out  1  sticky: a completed word was dropped
clr_ovf  in  1  clear ovf

Behaviour:
- Reset (rst_n=0 at edge): pointers 0, fill count 0, shift reg 0, ovf 0. Outputs after reset: empty=1, full=0, afull=0 (unless AF_LEVEL=0), level=0. q content is undefined (mem not reset).
- Packer:
  - fill counter 0..32 in bits; each wr adds 1, 4 or 8.
  - bus_w is latched on the first wr of a word (fill==0) and held until that word is pushed; mid-word bus_w changes are ignored.
- Bit order, default mode:
  - First byte received goes to q[7:0], second to q[15:8], and so on.
  - Within a byte, the earliest bits are most significant: 1-bit first sample lands in bit 7; 4-bit first nibble lands in [7:4].
- Push:
  - Occurs at the edge where fill reaches 32, or where flush=1 with resulting fill>0.
  - flush with wr in the same cycle includes that sample, then pads the remaining bits with 0. fill returns to 0.
  - flush with fill==0 and no wr is a no-op.
- Latency: the word is visible on q (empty=0) in the cycle after the completing wr/flush edge.
- Push acceptance: accepted if !full, or if full and rd=1 in the same cycle (simultaneous pop+push; level stays DEPTH).
  - Otherwise the word is discarded, ovf is set, and packing continues with the next sample.
- Pop: rd & !empty advances rd_ptr; rd while empty has no effect.
- Simultaneous push and pop when not full/empty: level unchanged, pointers both advance.
- Storage:
  - Pointers are AW+1 bits with the MSB as a wrap flag; index wraps DEPTH-1 -> 0 and toggles the MSB.
  - empty = ptr equal; full = index equal and MSB differ; level = wr_ptr - rd_ptr, modulo 2^(AW+1).
- ovf: set has priority over clr_ovf in the same cycle.
- Reset mid-word discards the partial word and all stored words.

Optional Feature:
SD_RX_BYTE_SWAP_EN:
- Defined: byte lanes are reversed at push. The first received byte goes to q[31:24] and the last to q[7:0]; bit order within a byte is unchanged. Padded bytes from flush are zeros in the low lanes.
- Undefined: the default little-endian lane order above.

Decomposition:
- Package sd_rx_pkg holds:
  - bus_w encodings: SD_BW_1, SD_BW_4, SD_BW_8
  - unit width per encoding (function returning 1/4/8)
  - word width constant SD_RX_WORD_W=32
- Sub-module sd_rx_packer contains the shift register, fill counter, bus_w latch and flush padding, and outputs push/word. The FIFO storage and flags stay in the top module.

Test Plan:
1. 4-bit mode, 8 wr with nibbles 1,2,...,8 -> one push; q=32'h78563412; level=1; empty falls one cycle after the 8th wr.
2. 1-bit mode, 32 wr with bits 1,0,1,0,... -> q=32'hAAAAAAAA; with SD_RX_BYTE_SWAP_EN q is identical. 8-bit mode bytes 11,22,33,44 -> q=32'h44332211, or 32'h11223344 with swap.
3. 8-bit mode, bytes A1,B2 then flush -> q=32'h0000B2A1 (swap: 32'hA1B20000). A following flush with no data -> no push.
4. DEPTH=8: push 8 words, no rd -> full=1, afull=1 from level 6. 9th word dropped -> ovf=1, level=8. clr_ovf -> ovf=0.
5. Full FIFO, 9th word completes in the same cycle as rd -> push accepted, level stays 8, ovf stays 0. Drain 8 -> words in order, empty=1, pointer wrap exercised twice.
6. rst_n=0 after 3 nibbles and 2 stored words -> empty=1, level=0. Next 8 nibbles form a clean word.
